// File: rtl/detect_tura.sv
`default_nettype none
// ============================================================================
// Module      : detect_tura
// Description : Lap detector for the line-follower car. Synchronises the raw
//               reflective line sensors, recognises the start/finish marker
//               (all sensors on black), confirms it over PRAG samples and
//               emits one single-cycle pulse per lap. A lockout window and a
//               re-arm condition (clear track first) prevent double counting.
// Ports       : clk        - system clock
//               reset      - asynchronous active-low reset
//               senzori    - raw asynchronous sensor levels (1 = black)
//               activ      - enable; 0 forces ARMARE with counters cleared
//               tura_puls  - registered one-cycle lap pulse (to count_ture.tact)
//               armat      - registered, high while in ARMAT
//               blocat     - registered, high while in BLOCARE
//               pe_linie   - synchronised marker flag (AND of second stage)
// Revision    : 1.0 - initial release
// ============================================================================
module detect_tura #(
    parameter int NR_SENZORI   = 5,
    parameter int PRAG         = 8,
    parameter int TIMP_BLOCARE = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NR_SENZORI-1:0] senzori,
    input  logic                  activ,
    output logic                  tura_puls,
    output logic                  armat,
    output logic                  blocat,
    output logic                  pe_linie
);

    localparam logic [7:0]  c_prag      = 8'(PRAG);
    localparam logic [7:0]  c_prag_m1   = 8'(PRAG - 1);
    localparam logic [19:0] c_blocare_m1 = 20'(TIMP_BLOCARE - 1);

    typedef enum logic [1:0] {
        ARMARE  = 2'd0,
        ARMAT   = 2'd1,
        PULS    = 2'd2,
        BLOCARE = 2'd3
    } state_t;

    // Two-flop synchroniser per sensor bit
    logic [NR_SENZORI-1:0] r_s1;
    logic [NR_SENZORI-1:0] r_s2;
    logic                  w_marker;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt_conf;
    logic [7:0]  w_cnt_conf_next;
    logic [19:0] r_cnt_bloc;
    logic [19:0] w_cnt_bloc_next;

    logic r_tura_puls;
    logic r_armat;
    logic r_blocat;

    assign w_marker = &r_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= senzori;
            r_s2 <= r_s1;
        end
    end

    // Confirmation counter increment, saturating at PRAG
    function automatic logic [7:0] conf_inc(input logic [7:0] v);
        return (v < c_prag) ? v + 8'd1 : v;
    endfunction

    always_comb begin
        w_state_next    = r_state;
        w_cnt_conf_next = r_cnt_conf;
        w_cnt_bloc_next = '0;

        case (r_state)
            ARMARE: begin
                // A car parked on the marker must first see clear track
                if (w_marker) begin
                    w_cnt_conf_next = '0;
                end else if (r_cnt_conf == c_prag_m1) begin
                    w_state_next    = ARMAT;
                    w_cnt_conf_next = '0;
                end else begin
                    w_cnt_conf_next = conf_inc(r_cnt_conf);
                end
            end
            ARMAT: begin
                if (!w_marker) begin
                    w_cnt_conf_next = '0;
                end else if (r_cnt_conf == c_prag_m1) begin
                    w_state_next    = PULS;
                    w_cnt_conf_next = '0;
                end else begin
                    w_cnt_conf_next = conf_inc(r_cnt_conf);
                end
            end
            PULS: begin
                w_state_next    = BLOCARE;
                w_cnt_conf_next = '0;
            end
            BLOCARE: begin
                w_cnt_conf_next = '0;
                if (r_cnt_bloc == c_blocare_m1) begin
                    w_state_next = ARMARE;
                end else begin
                    w_cnt_bloc_next = r_cnt_bloc + 20'd1;
                end
            end
            default: begin
                w_state_next    = ARMARE;
                w_cnt_conf_next = '0;
            end
        endcase

        // Disable overrides every transition
        if (!activ) begin
            w_state_next    = ARMARE;
            w_cnt_conf_next = '0;
            w_cnt_bloc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ARMARE;
            r_cnt_conf <= '0;
            r_cnt_bloc <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt_conf <= w_cnt_conf_next;
            r_cnt_bloc <= w_cnt_bloc_next;
        end
    end

    // Outputs registered from the next state so they track r_state exactly
    // and stay mutually exclusive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tura_puls <= 1'b0;
            r_armat     <= 1'b0;
            r_blocat    <= 1'b0;
        end else begin
            r_tura_puls <= (w_state_next == PULS);
            r_armat     <= (w_state_next == ARMAT);
            r_blocat    <= (w_state_next == BLOCARE);
        end
    end

    assign tura_puls = r_tura_puls;
    assign armat     = r_armat;
    assign blocat    = r_blocat;
    assign pe_linie  = w_marker;

endmodule
`default_nettype wire

// File: doc/detect_tura.md
# detect_tura

Lap detector for the line-follower car. Samples the raw reflective line sensors, recognises the start/finish marker (all sensors on black at once), confirms it over several clock cycles, and emits exactly one single-cycle pulse per lap. That pulse drives the `tact` input of `count_ture`, the BCD lap counter. A lockout window and a re-arm condition keep a single crossing from ever producing two pulses.

## Interface
- `NR_SENZORI`, 5: number of line sensors; the finish marker is all `NR_SENZORI` bits = 1.
- `PRAG`, 8: number of consecutive samples needed to confirm a pattern, for both marker and clear track; valid range 2..255.
- `TIMP_BLOCARE`, 50000: lockout length in clock cycles after a pulse; valid range 1..2^20-1.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `senzori`  in  NR_SENZORI  raw, asynchronous sensor levels (1 = black line).
- `activ`  in  1  enable. When 0, the block holds in the ARMARE state with counters cleared and `tura_puls` = 0.
- `tura_puls`  out  1  one-cycle lap pulse, registered; connects to `count_ture.tact`.
- `armat`  out  1  registered; 1 while in the ARMAT state.
- `blocat`  out  1  registered; 1 while in the BLOCARE state.
- `pe_linie`  out  1  synchronised marker flag: AND of the second-stage synchroniser bits.

## Operation
- Synchroniser: each `senzori` bit passes through 2 flip-flops (`s1` → `s2`). Define `marker` = &`s2`. `pe_linie` = `marker`.
- Counters:
  - `cnt_conf` is 8 bits and saturates at `PRAG`.
  - `cnt_bloc` is 20 bits.
  - Both clear on every state change.
- FSM states: ARMARE, ARMAT, PULS, BLOCARE. Reset state is ARMARE.
- ARMARE: require clear track before counting is allowed, so a car parked on the marker at power-up is not counted.
  - `marker` = 0: `cnt_conf`++.
  - `marker` = 1: `cnt_conf` ← 0.
  - Go to ARMAT on the edge where `cnt_conf` = `PRAG`-1 and `marker` = 0.
- ARMAT:
  - `marker` = 1: `cnt_conf`++.
  - `marker` = 0 (glitch): `cnt_conf` ← 0; stay in ARMAT.
  - Go to PULS on the edge where `cnt_conf` = `PRAG`-1 and `marker` = 1.
- PULS: lasts exactly one cycle; `tura_puls` = 1. Always goes to BLOCARE next.
- BLOCARE: `cnt_bloc`++ every cycle, sensors ignored. Go to ARMARE on the edge where `cnt_bloc` = `TIMP_BLOCARE`-1.
- `activ` = 0 has priority over every transition:
  - Next state is ARMARE and both counters clear.
  - If this happens while in PULS, the pulse already on the output completes its one cycle; no second pulse is generated.
- `reset` = 0 at any time, including mid-BLOCARE or mid-PULS:
  - Synchronisers, counters and outputs go to 0 immediately.
  - State goes to ARMARE.
- Output reset values: `tura_puls` = 0, `armat` = 0, `blocat` = 0, `pe_linie` = 0.

## Timing
- Latency from marker to pulse, with `senzori` all-ones and stable before edge E0 in state ARMAT:
  - `s2` all-ones after E1.
  - Marker samples are counted at edges E2..E(PRAG+1); the state becomes PULS after E(PRAG+1).
  - `tura_puls` is high from E(PRAG+1) to E(PRAG+2).
- Glitch rejection: a marker run shorter than `PRAG` samples produces no pulse.
- Pulse spacing: minimum distance between two pulses is 1 + `TIMP_BLOCARE` + `PRAG` (re-arm) + `PRAG` (confirm) cycles.
- `tura_puls` is never high for 2 consecutive cycles.
- `armat`, `blocat` and `tura_puls` are decoded from the registered state and are mutually exclusive.

## Test plan
Parameters for all scenarios: `PRAG` = 4, `TIMP_BLOCARE` = 16, `NR_SENZORI` = 5.

- Power-up on marker: release `reset` with `senzori` = 5'b11111 held 40 cycles → `tura_puls` stays 0 and `armat` stays 0.
- Clean lap: `senzori` = 5'b00100 for 10 cycles (`armat` = 1), then 5'b11111 for 10 cycles → exactly one pulse, 6 cycles after the first all-ones edge; `blocat` = 1 for the next 16 cycles.
- Glitch: in ARMAT, drive 5'b11111 for 3 cycles, then 5'b01110, repeated 5 times → no pulse; `armat` stays 1.
- Lockout: marker held 30 cycles after a pulse → exactly 1 pulse total. Then clear track 4+ cycles and marker again → second pulse. With `count_ture` attached, `cifra_unitati` = 2.
- Mid-operation reset: assert `reset` = 0 for 1 cycle during BLOCARE → all outputs 0 asynchronously; after release the FSM is in ARMARE and needs 4 clear samples to arm.
- Enable: deassert `activ` during ARMAT with `cnt_conf` = 2 → state goes to ARMARE and no pulse is produced. Reassert `activ` with marker present → no pulse until clear track has been seen.
